// File: rtl/kuuga_trace_pkg.sv
// Shared types and helpers for the latency tracing blocks.
// Timestamp width default and an elaboration-time log2 for occupancy counters.
package kuuga_trace_pkg;

    localparam int DEFAULT_TS_WIDTH = 16;

    typedef logic [DEFAULT_TS_WIDTH-1:0] ts_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// In-order timestamp FIFO; dout is the head, combinational from storage, count registered.
// No backpressure: a push into a full FIFO is taken only when a pop frees the slot that cycle.
module ts_fifo
    import kuuga_trace_pkg::*;
#(
    parameter  int W     = DEFAULT_TS_WIDTH,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // The extra wrap bit tells full from empty when the index bits are equal.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/delay_latency_monitor.sv
// Pairs start/end pulses in order and reports end-minus-start cycles, running max and sticky errors.
// Result appears one cycle after end_evt; no backpressure, excess starts are dropped and flagged.
module delay_latency_monitor
    import kuuga_trace_pkg::*;
#(
    parameter  int COUNTER_WIDTH   = DEFAULT_TS_WIDTH,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int OW              = clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_evt,
    input  logic                     end_evt,
    input  logic                     clear,
    output logic                     latency_valid,
    output logic [COUNTER_WIDTH-1:0] latency_value,
    output logic [COUNTER_WIDTH-1:0] max_latency,
    output logic [OW-1:0]            outstanding,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int CW = COUNTER_WIDTH;

    logic [CW-1:0] ts_q, ts_d;
    logic          lat_vld_q, lat_vld_d;
    logic [CW-1:0] lat_val_q, lat_val_d;
    logic [CW-1:0] max_q, max_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_head;
    logic          pair_direct;

    ts_fifo #(
        .W     (CW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_ts_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ts_q),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_comb begin
        ts_d        = ts_q + CW'(1);
        pair_direct = start_evt & end_evt & fifo_empty;
        fifo_pop    = end_evt & ~fifo_empty;
        fifo_push   = start_evt & ~pair_direct & (~fifo_full | fifo_pop);

        lat_vld_d = fifo_pop | pair_direct;
        lat_val_d = lat_val_q;
        if (fifo_pop) begin
            lat_val_d = ts_q - fifo_head;
        end else if (pair_direct) begin
            lat_val_d = '0;
        end

        // clear restarts the maximum from whatever result lands alongside it.
        max_d = max_q;
        if (clear) begin
            max_d = lat_vld_d ? lat_val_d : '0;
        end else if (lat_vld_d && (lat_val_d > max_q)) begin
            max_d = lat_val_d;
        end

        // A fresh error outranks clear so no event is ever lost.
        ovf_d = (ovf_q & ~clear) | (start_evt & fifo_full & ~fifo_pop);
        unf_d = (unf_q & ~clear) | (end_evt & fifo_empty & ~start_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            lat_vld_q <= 1'b0;
            lat_val_q <= '0;
            max_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            lat_vld_q <= lat_vld_d;
            lat_val_q <= lat_val_d;
            max_q     <= max_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign latency_valid = lat_vld_q;
    assign latency_value = lat_val_q;
    assign max_latency   = max_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_delay_latency_monitor.sv
// Directed bench: 16-bit monitor for pairing/errors/reset, 4-bit monitor for counter wrap.
module tb_delay_latency_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_drv, end_drv, clear, use_dly;
    logic        end_evt;
    logic [2:0]  dly_q;
    logic        latency_valid, overflow_err, underflow_err;
    logic [15:0] latency_value, max_latency;
    logic [2:0]  outstanding;

    logic        rst4_n, start4, end4, clear4;
    logic        latency_valid4, overflow_err4, underflow_err4;
    logic [3:0]  latency_value4, max_latency4;
    logic [2:0]  outstanding4;

    int n_cmp = 0;
    int n_bad = 0;

    // Three-cycle delay line standing in for a delay_module with CYCLES_TO_ADD=3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= {dly_q[1:0], start_drv};
    end
    assign end_evt = use_dly ? dly_q[2] : end_drv;

    delay_latency_monitor #(.COUNTER_WIDTH(16), .MAX_OUTSTANDING(4)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_evt     (start_drv),
        .end_evt       (end_evt),
        .clear         (clear),
        .latency_valid (latency_valid),
        .latency_value (latency_value),
        .max_latency   (max_latency),
        .outstanding   (outstanding),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    delay_latency_monitor #(.COUNTER_WIDTH(4), .MAX_OUTSTANDING(4)) u_dut4 (
        .clk           (clk),
        .rst_n         (rst4_n),
        .start_evt     (start4),
        .end_evt       (end4),
        .clear         (clear4),
        .latency_valid (latency_valid4),
        .latency_value (latency_value4),
        .max_latency   (max_latency4),
        .outstanding   (outstanding4),
        .overflow_err  (overflow_err4),
        .underflow_err (underflow_err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        int occ;
        int k;
        int lat_tab2 [4];
        int lat_tab3 [4];
        lat_tab2 = '{5, 6, 7, 8};
        lat_tab3 = '{5, 5, 5, 4};

        rst_n = 1'b0; rst4_n = 1'b0;
        start_drv = 1'b0; end_drv = 1'b0; clear = 1'b0; use_dly = 1'b0;
        start4 = 1'b0; end4 = 1'b0; clear4 = 1'b0;
        tick; tick;

        check("rst_vld", 32'(latency_valid), 32'd0);
        check("rst_val", 32'(latency_value), 32'd0);
        check("rst_max", 32'(max_latency),   32'd0);
        check("rst_occ", 32'(outstanding),   32'd0);
        check("rst_ovf", 32'(overflow_err),  32'd0);
        check("rst_unf", 32'(underflow_err), 32'd0);
        rst_n = 1'b1;

        // Test 1: start at ts=10 through the 3-cycle delay line.
        use_dly = 1'b1;
        repeat (10) tick;
        start_drv = 1'b1; tick; start_drv = 1'b0;
        tick; tick;
        check("t1_end_seen", 32'(end_evt), 32'd1);
        check("t1_vld_early", 32'(latency_valid), 32'd0);
        tick;
        check("t1_vld", 32'(latency_valid), 32'd1);
        check("t1_lat", 32'(latency_value), 32'd3);
        check("t1_max", 32'(max_latency),   32'd3);
        tick;
        check("t1_vld_after", 32'(latency_valid), 32'd0);
        use_dly = 1'b0;

        // Test 2: starts at 0..3, ends at 5,7,9,11.
        occ = 0; k = 0;
        for (int c = 0; c < 13; c++) begin
            logic s, e;
            s = (c < 4);
            e = (c == 5) || (c == 7) || (c == 9) || (c == 11);
            start_drv = s; end_drv = e;
            tick;
            occ = occ + int'(s) - int'(e);
            check("t2_vld", 32'(latency_valid), 32'(e));
            if (e) begin
                check("t2_lat", 32'(latency_value), 32'(lat_tab2[k]));
                k++;
            end
            check("t2_occ", 32'(outstanding), 32'(occ));
        end
        start_drv = 1'b0; end_drv = 1'b0;
        check("t2_max", 32'(max_latency), 32'd8);

        // Test 3: fill, overflow, then full start+end with a coincident clear.
        start_drv = 1'b1;
        repeat (4) tick;
        check("t3_full_occ", 32'(outstanding), 32'd4);
        check("t3_no_ovf", 32'(overflow_err), 32'd0);
        tick;
        check("t3_ovf", 32'(overflow_err), 32'd1);
        check("t3_ovf_occ", 32'(outstanding), 32'd4);
        end_drv = 1'b1; clear = 1'b1;
        tick;
        clear = 1'b0; start_drv = 1'b0;
        check("t3_se_ovf", 32'(overflow_err), 32'd0);
        check("t3_se_occ", 32'(outstanding), 32'd4);
        check("t3_se_vld", 32'(latency_valid), 32'd1);
        check("t3_se_lat", 32'(latency_value), 32'd5);
        check("t3_clr_max", 32'(max_latency), 32'd5);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_drain_lat", 32'(latency_value), 32'(lat_tab3[i]));
        end
        end_drv = 1'b0;
        check("t3_drain_occ", 32'(outstanding), 32'd0);
        check("t3_drain_max", 32'(max_latency), 32'd5);

        // Test 4: underflow, then same-cycle pair on an empty FIFO.
        end_drv = 1'b1;
        tick;
        check("t4_unf", 32'(underflow_err), 32'd1);
        check("t4_unf_vld", 32'(latency_valid), 32'd0);
        start_drv = 1'b1;
        tick;
        start_drv = 1'b0; end_drv = 1'b0;
        check("t4_pair_vld", 32'(latency_valid), 32'd1);
        check("t4_pair_lat", 32'(latency_value), 32'd0);
        check("t4_pair_occ", 32'(outstanding), 32'd0);

        // Test 5: 4-bit counter, start at ts=14, end at ts=3.
        rst4_n = 1'b1;
        repeat (14) tick;
        start4 = 1'b1; tick; start4 = 1'b0;
        repeat (4) tick;
        end4 = 1'b1; tick; end4 = 1'b0;
        check("t5_vld", 32'(latency_valid4), 32'd1);
        check("t5_lat", 32'(latency_value4), 32'd5);
        check("t5_max", 32'(max_latency4),   32'd5);

        // Test 6: asynchronous reset with two starts in flight.
        start_drv = 1'b1; tick; start_drv = 1'b0;
        end_drv = 1'b1; tick; end_drv = 1'b0;
        check("t6_pre_lat", 32'(latency_value), 32'd1);
        start_drv = 1'b1; tick; tick; start_drv = 1'b0;
        check("t6_pre_occ", 32'(outstanding), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_val", 32'(latency_value), 32'd0);
        check("t6_rst_max", 32'(max_latency),   32'd0);
        check("t6_rst_occ", 32'(outstanding),   32'd0);
        check("t6_rst_unf", 32'(underflow_err), 32'd0);
        check("t6_rst_vld", 32'(latency_valid), 32'd0);
        tick;
        rst_n = 1'b1;
        end_drv = 1'b1; tick; end_drv = 1'b0;
        check("t6_unf", 32'(underflow_err), 32'd1);
        check("t6_unf_vld", 32'(latency_valid), 32'd0);
        start_drv = 1'b1; tick; start_drv = 1'b0;
        end_drv = 1'b1; tick; end_drv = 1'b0;
        check("t6_max_set", 32'(max_latency), 32'd1);
        clear = 1'b1; tick; clear = 1'b0;
        check("t6_clr_unf", 32'(underflow_err), 32'd0);
        check("t6_clr_ovf", 32'(overflow_err),  32'd0);
        check("t6_clr_max", 32'(max_latency),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
